// File: rtl/sprite_line_fetch.sv
// Per-scanline sprite evaluator: walks the sprite object table, captures up to
// SLOTS hitting sprites (x plus one 8-pixel tile row each) for the line renderer.
module sprite_line_fetch #(
  parameter int NUM_SPRITES = 256,
  parameter int SLOTS       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        line_start_i,
  input  logic [8:0]  line_i,
  output logic        sprite_object_en_o,
  output logic [9:0]  sprite_object_addr_o,
  input  logic [15:0] sprite_object_data_i,
  output logic        tile_data_en_o,
  output logic [12:0] tile_data_addr_o,
  input  logic [15:0] tile_data_data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        overflow_o,
  input  logic [2:0]  slot_sel_i,
  output logic        slot_valid_o,
  output logic [9:0]  slot_x_o,
  output logic [31:0] slot_pixels_o
);

  localparam int CW = $clog2(SLOTS + 1);
  localparam logic [CW-1:0] SLOTS_C = CW'(SLOTS);
  localparam logic [7:0]    LAST_C  = 8'(NUM_SPRITES - 1);

  typedef enum logic [2:0] {
    IDLE, Y_RD, Y_CHK, X_CAP, T_CAP, R0_CAP, R1_CAP, DONE
  } state_t;

  state_t         state_q, state_d;
  logic [8:0]     line_q, line_d;
  logic [7:0]     sprite_q, sprite_d;
  logic [CW-1:0]  count_q, count_d;
  logic [2:0]     row_q, row_d;
  logic [9:0]     x_q, x_d;
  logic [8:0]     tile_q, tile_d;
  logic           hflip_q, hflip_d;
  logic [15:0]    hi_q, hi_d;
  logic           ovf_q, ovf_d;
  logic [9:0]     obj_addr_q, obj_addr_d;
  logic [12:0]    tile_addr_q, tile_addr_d;
  logic           obj_en, tile_en, clr_slots, wr_slot, done;

  logic           slot_valid_q [SLOTS];
  logic [9:0]     slot_x_q     [SLOTS];
  logic [31:0]    slot_pix_q   [SLOTS];

  logic [8:0]     row_full;
  logic           hit, last;
  logic [31:0]    pix_raw, pix_flip, pix_new;

  // Row wraps modulo 512 so sprites straddling the top of the frame still hit.
  assign row_full = line_q - sprite_object_data_i[8:0];
  assign hit      = sprite_object_data_i[15] && (row_full[8:3] == 6'd0);
  assign last     = (sprite_q == LAST_C);

  assign pix_raw = {hi_q, tile_data_data_i};
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_flip
      assign pix_flip[4*gi +: 4] = pix_raw[4*(7-gi) +: 4];
    end
  endgenerate
  assign pix_new = hflip_q ? pix_flip : pix_raw;

  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    sprite_d    = sprite_q;
    count_d     = count_q;
    row_d       = row_q;
    x_d         = x_q;
    tile_d      = tile_q;
    hflip_d     = hflip_q;
    hi_d        = hi_q;
    ovf_d       = ovf_q;
    obj_en      = 1'b0;
    obj_addr_d  = obj_addr_q;
    tile_en     = 1'b0;
    tile_addr_d = tile_addr_q;
    clr_slots   = 1'b0;
    wr_slot     = 1'b0;
    done        = 1'b0;
    case (state_q)
      IDLE: begin
        if (line_start_i) begin
          line_d    = line_i;
          count_d   = '0;
          ovf_d     = 1'b0;
          sprite_d  = 8'd0;
          clr_slots = 1'b1;
          state_d   = Y_RD;
        end
      end
      Y_RD: begin
        obj_en     = 1'b1;
        obj_addr_d = {sprite_q, 2'd0};
        state_d    = Y_CHK;
      end
      Y_CHK: begin
        if (!hit) begin
          if (last) begin
            state_d = DONE;
          end else begin
            sprite_d = sprite_q + 8'd1;
            state_d  = Y_RD;
          end
        end else if (count_q < SLOTS_C) begin
          row_d      = row_full[2:0];
          obj_en     = 1'b1;
          obj_addr_d = {sprite_q, 2'd1};
          state_d    = X_CAP;
        end else begin
          ovf_d   = 1'b1;
          state_d = DONE;
        end
      end
      X_CAP: begin
        x_d        = sprite_object_data_i[9:0];
        obj_en     = 1'b1;
        obj_addr_d = {sprite_q, 2'd2};
        state_d    = T_CAP;
      end
      T_CAP: begin
        tile_d      = sprite_object_data_i[8:0];
        hflip_d     = sprite_object_data_i[9];
        tile_en     = 1'b1;
        tile_addr_d = {sprite_object_data_i[8:0], row_q, 1'b0};
        state_d     = R0_CAP;
      end
      R0_CAP: begin
        hi_d        = tile_data_data_i;
        tile_en     = 1'b1;
        tile_addr_d = {tile_q, row_q, 1'b1};
        state_d     = R1_CAP;
      end
      R1_CAP: begin
        wr_slot = 1'b1;
        count_d = count_q + 1'b1;
        if (last) begin
          state_d = DONE;
        end else begin
          sprite_d = sprite_q + 8'd1;
          state_d  = Y_RD;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      line_q      <= '0;
      sprite_q    <= '0;
      count_q     <= '0;
      row_q       <= '0;
      x_q         <= '0;
      tile_q      <= '0;
      hflip_q     <= 1'b0;
      hi_q        <= '0;
      ovf_q       <= 1'b0;
      obj_addr_q  <= '0;
      tile_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      sprite_q    <= sprite_d;
      count_q     <= count_d;
      row_q       <= row_d;
      x_q         <= x_d;
      tile_q      <= tile_d;
      hflip_q     <= hflip_d;
      hi_q        <= hi_d;
      ovf_q       <= ovf_d;
      obj_addr_q  <= obj_addr_d;
      tile_addr_q <= tile_addr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) begin
        slot_valid_q[i] <= 1'b0;
        slot_x_q[i]     <= '0;
        slot_pix_q[i]   <= '0;
      end
    end else if (clr_slots) begin
      for (int i = 0; i < SLOTS; i++) begin
        slot_valid_q[i] <= 1'b0;
      end
    end else if (wr_slot) begin
      for (int i = 0; i < SLOTS; i++) begin
        if (count_q == CW'(i)) begin
          slot_valid_q[i] <= 1'b1;
          slot_x_q[i]     <= x_q;
          slot_pix_q[i]   <= pix_new;
        end
      end
    end
  end

  always_comb begin
    slot_valid_o  = 1'b0;
    slot_x_o      = '0;
    slot_pixels_o = '0;
    if (int'(slot_sel_i) < SLOTS) begin
      slot_valid_o  = slot_valid_q[slot_sel_i];
      slot_x_o      = slot_x_q[slot_sel_i];
      slot_pixels_o = slot_pix_q[slot_sel_i];
    end
  end

  // Addresses come straight from the next-state mux so the RAM sees them in
  // the issuing cycle, yet they hold their last value when not reading.
  assign sprite_object_en_o   = obj_en;
  assign sprite_object_addr_o = obj_addr_d;
  assign tile_data_en_o       = tile_en;
  assign tile_data_addr_o     = tile_addr_d;
  assign busy_o               = (state_q != IDLE);
  assign done_o               = done;
  assign overflow_o           = ovf_q;

endmodule
